// File: rtl/sprite_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sprite_layer_scheduler
// Description : Resolves one screen pixel from NREQ overlapping sprite layers
//               that share a single 16-entry palette. Layers are scanned in
//               fixed priority order (layer 0 first). Each covering layer's
//               palette index is presented to the palette, and the returned
//               colour is checked against the transparency key. The first
//               opaque colour wins. If no layer is opaque, BG_RGB is used.
// Build macro : PALETTE_PIPE_EN
//               Defined   - the palette is registered, so each valid layer
//                           takes two scan cycles (drive, then compare).
//               Undefined - the palette is combinational, so each layer
//                           takes one scan cycle.
// Ports       : Clk, Reset_n        clock, synchronous active-low reset
//               start               request a scan (ignored while busy)
//               layer_vld/layer_idx per-layer cover flag / palette index,
//                                   captured when a start is accepted
//               busy                scan in progress
//               pal_index/pal_rgb   shared palette address / returned colour
//               rgb_out/rgb_valid   resolved colour / one-cycle update pulse
//               hit/hit_layer       opaque layer found / its layer number
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_layer_scheduler #(
    parameter int          NREQ       = 4,
    parameter int          IDX_W      = 4,
    parameter logic [11:0] TRANSP_RGB = 12'hF1F,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic [NREQ-1:0]          layer_vld,
    input  logic [NREQ*IDX_W-1:0]    layer_idx,
    output logic                     busy,
    output logic [IDX_W-1:0]         pal_index,
    input  logic [11:0]              pal_rgb,
    output logic [11:0]              rgb_out,
    output logic                     rgb_valid,
    output logic                     hit,
    output logic [$clog2(NREQ)-1:0]  hit_layer
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_nxt;
    logic [NREQ-1:0]         r_vld;
    logic [NREQ*IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]        r_pal_hold;
    logic [IDX_W-1:0]        w_idx_arr [NREQ];

    logic w_accept;
    logic w_cur_vld;
    logic w_cmp;        // current layer's palette colour is valid this cycle
    logic w_stall;      // waiting on a registered palette for the current layer
    logic w_opaque;
    logic w_hit_commit;
    logic w_miss_commit;

    genvar k;
    generate
        for (k = 0; k < NREQ; k++) begin : g_idx_unpack
            assign w_idx_arr[k] = r_idx[k*IDX_W +: IDX_W];
        end
    endgenerate

    // Start is honoured in both IDLE and DONE so scans can run back to back.
    assign w_accept  = start && (r_state != SCAN);
    assign w_cur_vld = r_vld[r_ptr];
    assign w_opaque  = (pal_rgb != TRANSP_RGB);

`ifdef PALETTE_PIPE_EN
    // Phase 0 presents the index; phase 1 compares the registered palette
    // output for that same index.
    logic r_phase;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= (r_state == SCAN) && w_cur_vld && !r_phase;
        end
    end

    assign w_cmp   = (r_state == SCAN) && w_cur_vld && r_phase;
    assign w_stall = (r_state == SCAN) && w_cur_vld && !r_phase;
`else
    assign w_cmp   = (r_state == SCAN) && w_cur_vld;
    assign w_stall = 1'b0;
`endif

    assign w_hit_commit  = w_cmp && w_opaque;
    assign w_miss_commit = (r_state == SCAN) && !w_stall && !w_hit_commit
                           && (r_ptr == c_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SCAN;
                    w_ptr_nxt   = '0;
                end
            end
            SCAN: begin
                if (w_stall) begin
                    w_state_nxt = SCAN;
                end else if (w_hit_commit || w_miss_commit) begin
                    w_state_nxt = DONE;
                end else begin
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = SCAN;
                    w_ptr_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_vld      <= '0;
            r_idx      <= '0;
            r_pal_hold <= '0;
            rgb_out    <= '0;
            hit        <= 1'b0;
            hit_layer  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_pal_hold <= pal_index;
            if (w_accept) begin
                r_vld <= layer_vld;
                r_idx <= layer_idx;
            end
            if (w_hit_commit) begin
                rgb_out   <= pal_rgb;
                hit       <= 1'b1;
                hit_layer <= r_ptr;
            end else if (w_miss_commit) begin
                rgb_out   <= BG_RGB;
                hit       <= 1'b0;
                hit_layer <= '0;
            end
        end
    end

    // The index is live only while a covering layer is being looked up;
    // otherwise the last driven value is held so the palette stays quiet.
    assign pal_index = ((r_state == SCAN) && w_cur_vld) ? w_idx_arr[r_ptr] : r_pal_hold;
    assign busy      = (r_state == SCAN);
    assign rgb_valid = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_layer_scheduler
// Description : Self-checking bench for sprite_layer_scheduler. A palette
//               model supplies colours, and a layer-priority reference model
//               predicts the colour, hit, layer and latency of every scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_scheduler;

    localparam int          NREQ   = 4;
    localparam int          IDX_W  = 4;
    localparam int          HL_W   = 2;
    localparam logic [11:0] TRANSP = 12'hF1F;
    localparam logic [11:0] BG     = 12'h000;
`ifdef PALETTE_PIPE_EN
    localparam int VCOST = 2;
`else
    localparam int VCOST = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [NREQ-1:0]        layer_vld = '0;
    logic [NREQ*IDX_W-1:0]  layer_idx = '0;
    logic                   busy;
    logic [IDX_W-1:0]       pal_index;
    logic [11:0]            pal_rgb;
    logic [11:0]            rgb_out;
    logic                   rgb_valid;
    logic                   hit;
    logic [HL_W-1:0]        hit_layer;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_layer_scheduler #(
        .NREQ(NREQ), .IDX_W(IDX_W), .TRANSP_RGB(TRANSP), .BG_RGB(BG)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .start(start), .layer_vld(layer_vld),
        .layer_idx(layer_idx), .busy(busy), .pal_index(pal_index),
        .pal_rgb(pal_rgb), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
        .hit(hit), .hit_layer(hit_layer)
    );

    function automatic logic [11:0] pal_f(input logic [3:0] i);
        case (i)
            4'd1, 4'd6, 4'd10, 4'd11: pal_f = 12'hF1F;
            4'd0:  pal_f = 12'h242;
            4'd3:  pal_f = 12'h696;
            4'd12: pal_f = 12'h000;
            default: pal_f = {i, i ^ 4'h5, 4'h3};
        endcase
    endfunction

`ifdef PALETTE_PIPE_EN
    always @(posedge clk) pal_rgb <= pal_f(pal_index);
`else
    assign pal_rgb = pal_f(pal_index);
`endif

    // Priority resolution: first covering layer whose colour is not the key.
    // Latency = cycles spent on layers + 1 for the result cycle.
    task automatic model(input logic [NREQ-1:0] v, input logic [NREQ*IDX_W-1:0] ix,
                         output logic e_hit, output logic [HL_W-1:0] e_layer,
                         output logic [11:0] e_rgb, output int e_lat);
        int cost;
        logic [IDX_W-1:0] li;
        logic [11:0] c;
        cost = 0; e_hit = 1'b0; e_layer = '0; e_rgb = BG;
        for (int l = 0; l < NREQ; l++) begin
            if (!e_hit) begin
                if (v[l]) begin
                    cost += VCOST;
                    li = ix[l*IDX_W +: IDX_W];
                    c  = pal_f(li);
                    if (c != TRANSP) begin
                        e_hit = 1'b1; e_layer = HL_W'(l); e_rgb = c;
                    end
                end else begin
                    cost += 1;
                end
            end
        end
        e_lat = cost + 1;
    endtask

    task automatic do_scan(input logic [NREQ-1:0] v, input logic [NREQ*IDX_W-1:0] ix,
                           input string nm);
        logic e_hit; logic [HL_W-1:0] e_layer; logic [11:0] e_rgb; int e_lat;
        int cyc; bit seen;
        model(v, ix, e_hit, e_layer, e_rgb, e_lat);
        @(posedge clk); #1;
        layer_vld = v; layer_idx = ix; start = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            start = 1'b0;
            layer_vld = NREQ'($urandom);
            layer_idx = (NREQ*IDX_W)'($urandom);
            if (cyc == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL %s busy: got %b want 1", nm, busy);
                end
            end
            if (rgb_valid === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || cyc != e_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d (seen=%0b) want %0d", nm, cyc, seen, e_lat);
        end
        n_checks++;
        if (rgb_out !== e_rgb || hit !== e_hit || hit_layer !== e_layer) begin
            n_fail++;
            $display("FAIL %s result: got rgb=%h hit=%b layer=%0d want rgb=%h hit=%b layer=%0d",
                     nm, rgb_out, hit, hit_layer, e_rgb, e_hit, e_layer);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rgb_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL %s after: got valid=%b busy=%b want 0 0", nm, rgb_valid, busy);
        end
    endtask

    task automatic test_reset_state();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || rgb_valid !== 1'b0 || rgb_out !== 12'h0 || hit !== 1'b0 ||
            hit_layer !== '0 || pal_index !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b rgb=%h hit=%b layer=%0d idx=%0d want all 0",
                     busy, rgb_valid, rgb_out, hit, hit_layer, pal_index);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_top_hit();
        do_scan(4'b0001, 16'h0003, "top_hit");
        n_checks++;
        if (rgb_out !== 12'h696 || hit_layer !== 2'd0) begin
            n_fail++; $display("FAIL top_hit const: got rgb=%h layer=%0d want 696 0", rgb_out, hit_layer);
        end
    endtask

    task automatic test_reset_midscan();
        int vcount;
        @(posedge clk); #1;
        layer_vld = 4'b1111; layer_idx = 16'h6666; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        vcount = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rgb_valid === 1'b1) vcount++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (rgb_valid === 1'b1) vcount++;
        end
        n_checks++;
        if (vcount != 0) begin
            n_fail++; $display("FAIL reset_midscan valid: got %0d pulses want 0", vcount);
        end
        n_checks++;
        if (busy !== 1'b0 || rgb_out !== 12'h0 || hit !== 1'b0 || pal_index !== '0) begin
            n_fail++;
            $display("FAIL reset_midscan state: got busy=%b rgb=%h hit=%b idx=%0d want 0 0 0 0",
                     busy, rgb_out, hit, pal_index);
        end
    endtask

    task automatic test_fallthrough();
        do_scan(4'b0101, 16'h0001, "fallthrough");   // idx0=1 (key), idx2=0
        do_scan(4'b1111, 16'h6666, "all_transp");
        do_scan(4'b0000, 16'h3333, "none_valid");
        do_scan(4'b1000, 16'hC000, "black_opaque");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            do_scan(NREQ'($urandom), (NREQ*IDX_W)'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic e_hit; logic [HL_W-1:0] e_layer; logic [11:0] e_rgb; int e_lat;
        logic [NREQ*IDX_W-1:0] seq [6];
        int got, cyc, last;
        for (int s = 0; s < 6; s++) seq[s] = (s % 2 == 0) ? 16'h0003 : 16'h0000;
        model(4'b0001, 16'h0003, e_hit, e_layer, e_rgb, e_lat);
        @(posedge clk); #1;
        layer_vld = 4'b0001; layer_idx = seq[0]; start = 1'b1;
        got = 0; cyc = 0; last = 0;
        while (got < 6 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (rgb_valid === 1'b1) begin
                model(4'b0001, seq[got], e_hit, e_layer, e_rgb, e_lat);
                n_checks++;
                if (cyc - last != e_lat || rgb_out !== e_rgb || hit !== 1'b1) begin
                    n_fail++;
                    $display("FAIL back_to_back #%0d: got gap=%0d rgb=%h hit=%b want gap=%0d rgb=%h hit=1",
                             got, cyc - last, rgb_out, hit, e_lat, e_rgb);
                end
                last = cyc;
                got++;
                if (got < 6) layer_idx = seq[got];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (got != 6) begin
            n_fail++; $display("FAIL back_to_back count: got %0d want 6", got);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_start_while_busy();
        logic e_hit; logic [HL_W-1:0] e_layer; logic [11:0] e_rgb; int e_lat;
        int vcount, first;
        model(4'b1111, 16'hC666, e_hit, e_layer, e_rgb, e_lat);
        @(posedge clk); #1;
        layer_vld = 4'b1111; layer_idx = 16'hC666; start = 1'b1;
        vcount = 0; first = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = (c == 2);
            if (c == 2) begin layer_vld = 4'b0001; layer_idx = 16'h0003; end
            if (rgb_valid === 1'b1) begin
                vcount++;
                if (first == 0) begin
                    first = c;
                    n_checks++;
                    if (rgb_out !== e_rgb || hit !== 1'b1 || hit_layer !== 2'd3) begin
                        n_fail++;
                        $display("FAIL busy_start result: got rgb=%h hit=%b layer=%0d want %h 1 3",
                                 rgb_out, hit, hit_layer, e_rgb);
                    end
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (vcount != 1 || first != e_lat) begin
            n_fail++; $display("FAIL busy_start pulses: got %0d at %0d want 1 at %0d", vcount, first, e_lat);
        end
    endtask

    initial begin
        test_reset_state();
        test_top_hit();
        test_reset_midscan();
        test_fallthrough();
        test_back_to_back();
        test_start_while_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
